counter_updn_mod: RTL and testbench

- Parametrised successor to the team's 4-bit free-running up-counter.
- Adds up/down direction, a programmable terminal value (modulus), synchronous load and clear, and an enable prescaler.
- Offers wrap or saturate mode, plus registered overflow/underflow event pulses.
- Used as a general event/tick counter and timebase; default parameters keep plain 4-bit 0..15 wrap behaviour.

---
 rtl/counter_updn_mod.sv | 94 +++++++++
 tb/tb_counter_updn_mod.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/counter_updn_mod.sv
// Parametrised up/down counter with modulus, load/clear, enable prescaler,
// wrap/saturate mode and registered overflow/underflow pulses.
module counter_updn_mod #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VALUE = 15,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned      PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VALUE);
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    ps_q, ps_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             step;

    always_comb begin
        count_d     = count_q;
        ps_d        = ps_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        step        = 1'b0;

        if (clear) begin
            count_d = '0;
            ps_d    = '0;
        end else if (load) begin
            count_d = (load_value > MAX_V) ? MAX_V : load_value;
            ps_d    = '0;
        end else if (enable) begin
            if (ps_q == PS_LAST) begin
                ps_d = '0;
                step = 1'b1;
            end else begin
                ps_d = ps_q + PW'(1);
            end
        end

        if (step) begin
            if (up_dn) begin
                if (count_q == MAX_V) begin
                    overflow_d = 1'b1;
                    count_d    = (SATURATE != 0) ? MAX_V : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    underflow_d = 1'b1;
                    count_d     = (SATURATE != 0) ? '0 : MAX_V;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q     <= '0;
            ps_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            ps_q        <= ps_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign at_max    = (count_q == MAX_V);
    assign at_min    = (count_q == '0);

endmodule

// File: tb/tb_counter_updn_mod.sv
// Directed bench for counter_updn_mod: five parameterisations share one
// stimulus bus; each phase checks only the instance it targets.
module tb_counter_updn_mod;

    logic       clk = 1'b0;
    logic       reset_n, enable, up_dn, clear, load;
    logic [3:0] load_value;

    logic [3:0] cnt_def, cnt_mod, cnt_sat, cnt_ps3, cnt_ps4;
    logic       max_def, max_mod, max_sat, max_ps3, max_ps4;
    logic       min_def, min_mod, min_sat, min_ps3, min_ps4;
    logic       ovf_def, ovf_mod, ovf_sat, ovf_ps3, ovf_ps4;
    logic       unf_def, unf_mod, unf_sat, unf_ps3, unf_ps4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_updn_mod u_def (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn),
        .clear(clear), .load(load), .load_value(load_value),
        .count(cnt_def), .at_max(max_def), .at_min(min_def),
        .overflow(ovf_def), .underflow(unf_def));

    counter_updn_mod #(.WIDTH(4), .MAX_VALUE(9)) u_mod (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn),
        .clear(clear), .load(load), .load_value(load_value),
        .count(cnt_mod), .at_max(max_mod), .at_min(min_mod),
        .overflow(ovf_mod), .underflow(unf_mod));

    counter_updn_mod #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1)) u_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn),
        .clear(clear), .load(load), .load_value(load_value),
        .count(cnt_sat), .at_max(max_sat), .at_min(min_sat),
        .overflow(ovf_sat), .underflow(unf_sat));

    counter_updn_mod #(.PRESCALE(3)) u_ps3 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn),
        .clear(clear), .load(load), .load_value(load_value),
        .count(cnt_ps3), .at_max(max_ps3), .at_min(min_ps3),
        .overflow(ovf_ps3), .underflow(unf_ps3));

    counter_updn_mod #(.PRESCALE(4)) u_ps4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn),
        .clear(clear), .load(load), .load_value(load_value),
        .count(cnt_ps4), .at_max(max_ps4), .at_min(min_ps4),
        .overflow(ovf_ps4), .underflow(unf_ps4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; up_dn = 1'b1;
        clear = 1'b0; load = 1'b0; load_value = '0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset with enable high must still yield zeroed state.
        reset_n = 1'b0; enable = 1'b1; up_dn = 1'b1;
        clear = 1'b0; load = 1'b0; load_value = '0;
        tick(); tick();
        chk("rst_count", 32'(cnt_def), 0);
        chk("rst_at_min", 32'(min_def), 1);
        chk("rst_at_max", 32'(max_def), 0);
        chk("rst_ovf", 32'(ovf_def), 0);
        chk("rst_unf", 32'(unf_def), 0);

        // Default 0..15 wrap-up run.
        reset_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("def_count", 32'(cnt_def), 32'(i % 16));
            chk("def_ovf", 32'(ovf_def), (i == 16) ? 1 : 0);
            chk("def_at_max", 32'(max_def), (i == 15) ? 1 : 0);
        end

        // Modulus 9 down-count across zero.
        do_reset();
        load = 1'b1; load_value = 4'd2;
        tick();
        chk("mod_load", 32'(cnt_mod), 2);
        load = 1'b0; up_dn = 1'b0; enable = 1'b1;
        tick(); chk("mod_dn1", 32'(cnt_mod), 1); chk("mod_unf1", 32'(unf_mod), 0);
        tick(); chk("mod_dn0", 32'(cnt_mod), 0); chk("mod_unf0", 32'(unf_mod), 0);
        tick(); chk("mod_dn9", 32'(cnt_mod), 9); chk("mod_unf9", 32'(unf_mod), 1);
        chk("mod_ovf9", 32'(ovf_mod), 0);
        tick(); chk("mod_dn8", 32'(cnt_mod), 8); chk("mod_unf8", 32'(unf_mod), 0);

        // Saturate at MAX_VALUE 9.
        do_reset();
        load = 1'b1; load_value = 4'd8;
        tick();
        load = 1'b0; up_dn = 1'b1; enable = 1'b1;
        tick(); chk("sat_c1", 32'(cnt_sat), 9); chk("sat_ovf1", 32'(ovf_sat), 0);
        tick(); chk("sat_c2", 32'(cnt_sat), 9); chk("sat_ovf2", 32'(ovf_sat), 1);
        tick(); chk("sat_c3", 32'(cnt_sat), 9); chk("sat_ovf3", 32'(ovf_sat), 1);
        chk("sat_at_max", 32'(max_sat), 1);
        // Saturating down at zero holds and flags underflow.
        clear = 1'b1; enable = 1'b0;
        tick();
        clear = 1'b0; up_dn = 1'b0; enable = 1'b1;
        tick(); chk("sat_dn_hold", 32'(cnt_sat), 0); chk("sat_unf", 32'(unf_sat), 1);

        // Prescale by 3.
        do_reset();
        enable = 1'b1; up_dn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("ps3_count", 32'(cnt_ps3), 32'(k / 3));
        end
        tick();
        chk("ps3_gap_a", 32'(cnt_ps3), 3);
        enable = 1'b0;
        tick(); chk("ps3_gap_b", 32'(cnt_ps3), 3);
        tick(); chk("ps3_gap_c", 32'(cnt_ps3), 3);
        enable = 1'b1;
        tick(); chk("ps3_gap_d", 32'(cnt_ps3), 3);
        tick(); chk("ps3_gap_step", 32'(cnt_ps3), 4);

        // Priority: clear over load, then load clamp, load suppresses step.
        do_reset();
        load = 1'b1; load_value = 4'd5;
        tick(); chk("pri_load5", 32'(cnt_mod), 5);
        clear = 1'b1; load_value = 4'd7;
        tick(); chk("pri_clear", 32'(cnt_mod), 0);
        clear = 1'b0; load_value = 4'd13;
        tick(); chk("pri_clamp", 32'(cnt_mod), 9); chk("pri_at_max", 32'(max_mod), 1);
        load_value = 4'd9; enable = 1'b1; up_dn = 1'b1;
        tick(); chk("pri_ld_cnt", 32'(cnt_mod), 9); chk("pri_ld_ovf", 32'(ovf_mod), 0);
        load = 1'b0;
        tick(); chk("pri_wrap", 32'(cnt_mod), 0); chk("pri_wrap_ovf", 32'(ovf_mod), 1);

        // Reset mid-window discards prescaler progress.
        do_reset();
        load = 1'b1; load_value = 4'd6; enable = 1'b1; up_dn = 1'b1;
        tick(); chk("ps4_load", 32'(cnt_ps4), 6);
        load = 1'b0;
        tick(); tick();
        chk("ps4_pre", 32'(cnt_ps4), 6);
        reset_n = 1'b0;
        tick(); chk("ps4_rst", 32'(cnt_ps4), 0);
        reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("ps4_after", 32'(cnt_ps4), (k == 4) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
